// File: rtl/axi_intc_pkg.sv
// Shared constants and types for the interrupt-controller sequencer.
package axi_intc_pkg;

    localparam int unsigned AXI_ADDR_W = 9;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned VEC_ID_W   = 5;

    // Interrupt controller register offsets
    localparam logic [AXI_ADDR_W-1:0] ADDR_ISR = 9'h000;
    localparam logic [AXI_ADDR_W-1:0] ADDR_IER = 9'h008;
    localparam logic [AXI_ADDR_W-1:0] ADDR_IAR = 9'h00C;
    localparam logic [AXI_ADDR_W-1:0] ADDR_IVR = 9'h018;
    localparam logic [AXI_ADDR_W-1:0] ADDR_MER = 9'h01C;

    // ME | HIE: master enable plus hardware interrupt enable
    localparam logic [AXI_DATA_W-1:0] MER_INIT = 32'h0000_0003;
    // IVR value meaning "no interrupt pending"
    localparam logic [AXI_DATA_W-1:0] IVR_NONE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_B_IER,
        ST_B_MER,
        ST_IDLE,
        ST_RD_IVR,
        ST_VEC,
        ST_WR_IAR,
        ST_WR_IER
    } seq_state_e;

    typedef enum logic [2:0] {
        ENG_IDLE,
        ENG_WR,
        ENG_BRESP,
        ENG_AR,
        ENG_R
    } eng_state_e;

    // One AXI-Lite access as issued by the sequencer
    typedef struct packed {
        logic                  we;
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_DATA_W-1:0] wdata;
    } axil_req_t;

endpackage

// File: rtl/axi_lite_single_master.sv
// One-shot AXI-Lite master: runs a single write or read per start and
// reports completion combinationally on the cycle the response handshakes.
module axi_lite_single_master
    import axi_intc_pkg::*;
(
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  start_i,
    input  axil_req_t             req_i,
    output logic                  done_c_o,
    output logic [AXI_DATA_W-1:0] rdata_c_o,
    output logic                  err_c_o,

    output logic [AXI_ADDR_W-1:0] m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [AXI_DATA_W-1:0] m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [AXI_ADDR_W-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [AXI_DATA_W-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    eng_state_e            st_q, st_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [AXI_DATA_W-1:0] wdata_q, wdata_d;
    logic                  done_c;
    logic                  err_c;
    logic                  aw_hs_c;
    logic                  w_hs_c;

    assign aw_hs_c = awvalid_q & m_awready;
    assign w_hs_c  = wvalid_q & m_wready;

    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = 4'hF;
    assign m_awvalid = awvalid_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

    assign done_c_o  = done_c;
    assign err_c_o   = err_c;
    assign rdata_c_o = m_rdata;

    // Channel handshakes; a new request may launch on the completion cycle
    always_comb begin
        st_d      = st_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_c    = 1'b0;
        err_c     = 1'b0;

        case (st_q)
            ENG_WR: begin
                if (aw_hs_c) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs_c) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs_c) && (w_done_q | w_hs_c)) begin
                    bready_d = 1'b1;
                    st_d     = ENG_BRESP;
                end
            end
            ENG_BRESP: begin
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    done_c   = 1'b1;
                    err_c    = (m_bresp != 2'b00);
                    st_d     = ENG_IDLE;
                end
            end
            ENG_AR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    st_d      = ENG_R;
                end
            end
            ENG_R: begin
                if (m_rvalid) begin
                    rready_d = 1'b0;
                    done_c   = 1'b1;
                    err_c    = (m_rresp != 2'b00);
                    st_d     = ENG_IDLE;
                end
            end
            default: ;
        endcase

        if (start_i && ((st_q == ENG_IDLE) || done_c)) begin
            addr_d  = req_i.addr;
            wdata_d = req_i.wdata;
            if (req_i.we) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                st_d      = ENG_WR;
            end else begin
                arvalid_d = 1'b1;
                st_d      = ENG_AR;
            end
        end
    end

    // Engine state and channel registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            st_q      <= ENG_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            st_q      <= st_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule

// File: rtl/axi_intc_sequencer.sv
// Owns the interrupt controller register port: boot programming, vector
// fetch and acknowledge, and serialised runtime IER updates.
module axi_intc_sequencer
    import axi_intc_pkg::*;
#(
    parameter int unsigned           NUM_IRQ  = 8,
    parameter logic [AXI_DATA_W-1:0] INIT_IER = 32'h0000_0000
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    output logic [AXI_ADDR_W-1:0] m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [AXI_DATA_W-1:0] m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [AXI_ADDR_W-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [AXI_DATA_W-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,

    input  logic                  irq_i,
    output logic                  vec_valid_o,
    output logic [VEC_ID_W-1:0]   vec_id_o,
    input  logic                  vec_ack_i,
    input  logic                  cfg_req_i,
    input  logic [AXI_DATA_W-1:0] cfg_ier_i,
    output logic                  cfg_ready_o,
    output logic                  init_done_o,
    output logic                  err_o
);

    seq_state_e            st_q, st_d;
    logic                  boot_q;
    logic                  vec_valid_q, vec_valid_d;
    logic [VEC_ID_W-1:0]   vec_id_q, vec_id_d;
    logic                  init_done_q, init_done_d;
    logic                  err_q, err_d;

    logic                  start_c;
    axil_req_t             req_c;
    logic                  eng_done_c;
    logic                  eng_err_c;
    logic [AXI_DATA_W-1:0] eng_rdata_c;
    logic [AXI_DATA_W-1:0] ivr_c;

    assign vec_valid_o = vec_valid_q;
    assign vec_id_o    = vec_id_q;
    assign init_done_o = init_done_q;
    assign err_o       = err_q;
    // An interrupt in IDLE always beats a pending configuration request
    assign cfg_ready_o = (st_q == ST_IDLE) && !irq_i;

    // A failed IVR read is treated as "nothing pending"
    assign ivr_c = eng_err_c ? IVR_NONE : eng_rdata_c;

    axi_lite_single_master u_master (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start_i   (start_c),
        .req_i     (req_c),
        .done_c_o  (eng_done_c),
        .rdata_c_o (eng_rdata_c),
        .err_c_o   (eng_err_c),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready)
    );

    // Sequencing FSM; each transaction is launched on entry to its state
    always_comb begin
        st_d        = st_q;
        vec_valid_d = vec_valid_q;
        vec_id_d    = vec_id_q;
        init_done_d = init_done_q;
        err_d       = err_q | eng_err_c;
        start_c     = 1'b0;
        req_c.we    = 1'b1;
        req_c.addr  = ADDR_IER;
        req_c.wdata = INIT_IER;

        case (st_q)
            ST_B_IER: begin
                if (boot_q) begin
                    start_c = 1'b1;
                end
                if (eng_done_c) begin
                    st_d        = ST_B_MER;
                    start_c     = 1'b1;
                    req_c.addr  = ADDR_MER;
                    req_c.wdata = MER_INIT;
                end
            end
            ST_B_MER: begin
                if (eng_done_c) begin
                    st_d        = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (irq_i) begin
                    st_d        = ST_RD_IVR;
                    start_c     = 1'b1;
                    req_c.we    = 1'b0;
                    req_c.addr  = ADDR_IVR;
                    req_c.wdata = '0;
                end else if (cfg_req_i) begin
                    st_d        = ST_WR_IER;
                    start_c     = 1'b1;
                    req_c.wdata = cfg_ier_i;
                end
            end
            ST_RD_IVR: begin
                if (eng_done_c) begin
                    if ((ivr_c == IVR_NONE) || (ivr_c >= 32'(NUM_IRQ))) begin
                        st_d = ST_IDLE;
                    end else begin
                        vec_id_d    = ivr_c[VEC_ID_W-1:0];
                        vec_valid_d = 1'b1;
                        st_d        = ST_VEC;
                    end
                end
            end
            ST_VEC: begin
                if (vec_ack_i) begin
                    vec_valid_d = 1'b0;
                    st_d        = ST_WR_IAR;
                    start_c     = 1'b1;
                    req_c.addr  = ADDR_IAR;
                    req_c.wdata = 32'(1) << vec_id_q;
                end
            end
            ST_WR_IAR, ST_WR_IER: begin
                if (eng_done_c) begin
                    st_d = ST_IDLE;
                end
            end
            default: st_d = ST_B_IER;
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            st_q        <= ST_B_IER;
            boot_q      <= 1'b1;
            vec_valid_q <= 1'b0;
            vec_id_q    <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            st_q        <= st_d;
            boot_q      <= 1'b0;
            vec_valid_q <= vec_valid_d;
            vec_id_q    <= vec_id_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: doc/axi_intc_sequencer.md
Name: axi_intc_sequencer

Overview:
- AXI-Lite master that owns the register port of the SoC interrupt controller (Xilinx-style map: ISR 0x00, IER 0x08, IAR 0x0C, IVR 0x18, MER 0x1C).
- After reset it programs IER and MER.
- On irq it reads IVR and presents a hardware vector to the CPU. Once the CPU accepts the vector, it acknowledges the interrupt through IAR.
- It also serialises runtime IER updates from a CPU-side request port.

Parameters:
- NUM_IRQ, 8, number of interrupt inputs on the controller (1..32).
- INIT_IER, 32'h0000_0000, value written to IER after reset.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- m_awaddr  out  9  AXI-Lite write address
- m_awvalid  out  1  write address valid
- m_awready  in  1  write address ready
- m_wdata  out  32  write data
- m_wstrb  out  4  write strobes; always 4'hF
- m_wvalid  out  1  write data valid
- m_wready  in  1  write data ready
- m_bresp  in  2  write response
- m_bvalid  in  1  write response valid
- m_bready  out  1  write response ready
- m_araddr  out  9  read address
- m_arvalid  out  1  read address valid
- m_arready  in  1  read address ready
- m_rdata  in  32  read data
- m_rresp  in  2  read response
- m_rvalid  in  1  read data valid
- m_rready  out  1  read data ready
- irq_i  in  1  irq output of the interrupt controller
- vec_valid_o  out  1  vector available
- vec_id_o  out  5  interrupt number
- vec_ack_i  in  1  CPU accepts vector; qualifies with vec_valid_o
- cfg_req_i  in  1  request an IER write
- cfg_ier_i  in  32  IER value; sampled when cfg_req_i && cfg_ready_o
- cfg_ready_o  out  1  high only in IDLE
- init_done_o  out  1  boot programming finished
- err_o  out  1  sticky: any non-OKAY bresp/rresp

Behaviour:
- Reset: every valid/ready output is 0; init_done_o, err_o and vec_valid_o are 0; vec_id_o is 0; state is B_IER.
- Write transaction:
  - Assert awvalid and wvalid in the same cycle.
  - Deassert each independently on its own ready, tracked by aw_done/w_done flags.
  - Once both flags are set, assert bready and wait for bvalid; that is the completion point.
  - Address and data stay stable while valid is high.
- Read transaction:
  - Assert arvalid until arready.
  - Then assert rready and wait for rvalid; capture rdata on that cycle.
- No outstanding overlap: at most one transaction at a time.
- Response errors: resp != 2'b00 sets err_o until reset. The FSM proceeds normally; for an IVR read, an error response is treated as 32'hFFFF_FFFF.
- States and transitions:
  - B_IER: write INIT_IER to 0x08 -> B_MER.
  - B_MER: write 32'h3 to 0x1C (ME|HIE) -> IDLE; init_done_o rises the cycle after bvalid and stays high.
  - IDLE priority: irq_i first -> RD_IVR; else cfg_req_i -> WR_IER with cfg_ier_i latched.
  - RD_IVR: read 0x18.
    - rdata == 32'hFFFF_FFFF, or rdata >= NUM_IRQ: -> IDLE (spurious).
    - Otherwise latch vec_id_o = rdata[4:0] -> VEC.
  - VEC: vec_valid_o = 1; on vec_ack_i -> WR_IAR; vec_valid_o drops the next cycle.
  - WR_IAR: write (1 << vec_id) to 0x0C -> IDLE.
  - WR_IER: write the latched value to 0x08 -> IDLE.
- cfg_ready_o is combinationally (state == IDLE && !irq_i), so an interrupt always wins a simultaneous cfg request.
- Minimum latency, slave with zero-wait ready/valid:
  - irq_i to vec_valid_o: 3 cycles (IDLE->RD_IVR, AR, R).
  - vec_ack_i to back in IDLE: 3 cycles.
- Level irq_i still high after IAR (other pending source): IDLE re-enters RD_IVR immediately.
- vec_ack_i outside VEC is ignored. cfg_req_i outside IDLE is not accepted; the requester holds it.
- Reset mid-transaction: all valids drop asynchronously. The controller is reset by the same aresetn, so no half-finished transaction survives.

Decomposition:
- Package axi_intc_pkg holds:
  - register offset localparams (ISR/IER/IAR/IVR/MER);
  - MER_INIT = 32'h3;
  - IVR_NONE = 32'hFFFF_FFFF;
  - the state enum typedef.
- Sub-module axi_lite_single_master:
  - one-shot write/read engine with start/we/addr/wdata inputs and done/rdata/err outputs;
  - owns the aw/w/b/ar/r handshakes.
- The top contains only the sequencing FSM.

Test Plan:
- Reset release with INIT_IER=32'h0F and a zero-wait slave -> writes (0x08, 0x0F) then (0x1C, 0x3) in order; init_done_o high after the second bvalid; err_o = 0.
- Slave holds awready low 3 cycles while wready is immediate -> wvalid drops after 1 cycle, awvalid held with a stable address, exactly one bready/bvalid completion.
- irq_i=1 with IVR returning 5, CPU acks 4 cycles later:
  - vec_valid_o=1 and vec_id_o=5 until the ack;
  - then a write of (0x0C, 32'h20);
  - back in IDLE.
- irq_i=1 with IVR returning 32'hFFFF_FFFF -> no vec_valid_o, no IAR write, returns to IDLE.
- cfg_req_i with cfg_ier_i=32'hA5 asserted in the same cycle as irq_i -> IVR read and IAR write first, then write (0x08, 32'hA5); cfg_ready_o low until IDLE is reached with irq_i low.
- bresp=2'b10 on the MER write -> err_o sticky high, init_done_o still rises; aresetn pulse mid-RD_IVR -> all valids 0 asynchronously, sequence restarts at B_IER.
